sap1_datapath: RTL and testbench

Consumer side of the 15-bit SAP-1 control word. Owns the 8-bit W-bus, program counter, MAR, MDR, 16x8 RAM, instruction register, accumulator A, register B, adder/subtractor and output register. Each cycle it decodes the control word driven by the control block, resolves the single bus driver, and latches the bus into every enabled destination on posedge clk. It returns the IR opcode nibble to the control block.

---
 rtl/sap1_pkg.sv | 48 ++++
 rtl/sap1_ram16x8.sv | 29 ++
 rtl/sap1_datapath.sv | 134 +++++++++++++
 tb/tb_sap1_datapath.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// sap1_pkg: constants shared by the SAP-1 control block and datapath.
//   - bit positions of the 15-bit control word (MSB C_P .. LSB /L_O)
//   - opcode encodings carried in ir[7:4]
//   - the all-deasserted control word (pure hold)
//   - helper that counts how many W-bus drivers a control word enables
package sap1_pkg;

  localparam int CTRL_W = 15;

  localparam int SIG_PC_INC     = 14;  // C_P
  localparam int SIG_PC_EN      = 13;  // E_P
  localparam int SIG_PC_LOAD    = 12;  // L_P
  localparam int SIG_MAR_LOAD_N = 11;  // /L_MA
  localparam int SIG_MDR_LOAD_N = 10;  // /L_MD
  localparam int SIG_RAM_EN_N   = 9;   // /CE
  localparam int SIG_RAM_LOAD_N = 8;   // /L_R
  localparam int SIG_IR_LOAD_N  = 7;   // /L_I
  localparam int SIG_IR_EN_N    = 6;   // /E_I
  localparam int SIG_A_LOAD_N   = 5;   // /L_A
  localparam int SIG_A_EN       = 4;   // E_A
  localparam int SIG_SUB        = 3;   // S_U
  localparam int SIG_ALU_EN     = 2;   // E_U
  localparam int SIG_B_LOAD_N   = 1;   // /L_B
  localparam int SIG_OUT_LOAD_N = 0;   // /L_O

  typedef enum logic [3:0] {
    OP_HLT = 4'h0,
    OP_OUT = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_LDA = 4'h4,
    OP_STA = 4'h5,
    OP_LDI = 4'h6,
    OP_JMP = 4'h7
  } opcode_e;

  localparam logic [CTRL_W-1:0] CTRL_IDLE = 15'b000111111100011;

  // Number of enabled bus drivers; active-low enables are inverted first.
  function automatic logic [2:0] bus_driver_count(input logic [CTRL_W-1:0] c);
    return {2'b00, c[SIG_PC_EN]}
         + {2'b00, ~c[SIG_RAM_EN_N]}
         + {2'b00, ~c[SIG_IR_EN_N]}
         + {2'b00, c[SIG_A_EN]}
         + {2'b00, c[SIG_ALU_EN]};
  endfunction

endpackage

// File: rtl/sap1_ram16x8.sv
// sap1_ram16x8: SAP-1 program/data memory.
//   clk      : write clock
//   we_i     : write enable (already muxed between program load and /L_R)
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : asynchronous read address (MAR)
//   rdata_o  : asynchronous read data
// Contents survive reset so a loaded program is kept across resets.
module sap1_ram16x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sap1_datapath.sv
// sap1_datapath: SAP-1 datapath consuming the 15-bit control word.
//   clk          : system clock, all state updates on posedge
//   resetn       : asynchronous active-low reset (RAM contents kept)
//   ctrl         : control word C_P,E_P,L_P,/L_MA,/L_MD,/CE,/L_R,/L_I,/E_I,/L_A,E_A,S_U,E_U,/L_B,/L_O
//   opcode       : ir[7:4] back to the control block
//   out_data     : output register
//   out_valid    : one-cycle pulse after the output register loads
//   prog_we/addr/data : program-load write port, wins over /L_R
//   bus_dbg      : combinational W-bus value
//   bus_conflict : sticky multi-driver flag
// Optional feature: define SAP1_DP_CONTENTION_CHK_EN to build the bus
// contention detector; otherwise bus_conflict is tied low.
module sap1_datapath
  import sap1_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [CTRL_W-1:0] ctrl,
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] bus_dbg,
  output logic              bus_conflict
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;

  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  // Subtraction as two's-complement add so one adder serves both.
  assign alu_res = ctrl[SIG_SUB] ? (a_q + ~b_q + DATA_W'(1)) : (a_q + b_q);

  always_comb begin
    bus = '0;
    if (ctrl[SIG_PC_EN])          bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
    else if (!ctrl[SIG_RAM_EN_N]) bus = ram_rdata;
    else if (!ctrl[SIG_IR_EN_N])  bus = {{(DATA_W-4){1'b0}}, ir_q[3:0]};
    else if (ctrl[SIG_A_EN])      bus = a_q;
    else if (ctrl[SIG_ALU_EN])    bus = alu_res;
  end

  always_comb begin
    pc_d = pc_q;
    if (ctrl[SIG_PC_LOAD])     pc_d = bus[ADDR_W-1:0];
    else if (ctrl[SIG_PC_INC]) pc_d = pc_q + ADDR_W'(1);

    mar_d       = ctrl[SIG_MAR_LOAD_N] ? mar_q : bus[ADDR_W-1:0];
    mdr_d       = ctrl[SIG_MDR_LOAD_N] ? mdr_q : bus;
    ir_d        = ctrl[SIG_IR_LOAD_N]  ? ir_q  : bus;
    a_d         = ctrl[SIG_A_LOAD_N]   ? a_q   : bus;
    b_d         = ctrl[SIG_B_LOAD_N]   ? b_q   : bus;
    out_d       = ctrl[SIG_OUT_LOAD_N] ? out_q : bus;
    out_valid_d = ~ctrl[SIG_OUT_LOAD_N];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q        <= '0;
      mar_q       <= '0;
      mdr_q       <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Program loading owns the write port; a coincident /L_R store is dropped.
  assign ram_we    = prog_we | ~ctrl[SIG_RAM_LOAD_N];
  assign ram_waddr = prog_we ? prog_addr : mar_q;
  assign ram_wdata = prog_we ? prog_data : mdr_q;

  sap1_ram16x8 #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (mar_q),
    .rdata_o (ram_rdata)
  );

`ifdef SAP1_DP_CONTENTION_CHK_EN
  logic conflict_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      conflict_q <= 1'b0;
    end else if (bus_driver_count(ctrl) > 3'd1) begin
      conflict_q <= 1'b1;
    end
  end

  assign bus_conflict = conflict_q;
`else
  assign bus_conflict = 1'b0;
`endif

  assign opcode    = ir_q[DATA_W-1 -: 4];
  assign out_data  = out_q;
  assign out_valid = out_valid_q;
  assign bus_dbg   = bus;

endmodule

// File: tb/tb_sap1_datapath.sv
module tb_sap1_datapath;

  localparam logic [14:0] IDLE  = 15'b000111111100011;
  localparam logic [14:0] M_CP  = 15'h4000;
  localparam logic [14:0] M_EP  = 15'h2000;
  localparam logic [14:0] M_LP  = 15'h1000;
  localparam logic [14:0] M_LMA = 15'h0800;
  localparam logic [14:0] M_LMD = 15'h0400;
  localparam logic [14:0] M_CE  = 15'h0200;
  localparam logic [14:0] M_LR  = 15'h0100;
  localparam logic [14:0] M_LI  = 15'h0080;
  localparam logic [14:0] M_EI  = 15'h0040;
  localparam logic [14:0] M_LA  = 15'h0020;
  localparam logic [14:0] M_EA  = 15'h0010;
  localparam logic [14:0] M_SU  = 15'h0008;
  localparam logic [14:0] M_EU  = 15'h0004;
  localparam logic [14:0] M_LB  = 15'h0002;
  localparam logic [14:0] M_LO  = 15'h0001;

`ifdef SAP1_DP_CONTENTION_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [14:0] ctrl;
  logic [3:0]  opcode;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [7:0]  bus_dbg;
  logic        bus_conflict;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state (architectural view of the machine)
  logic [3:0] m_pc, m_mar;
  logic [7:0] m_mdr, m_ir, m_a, m_b, m_out;
  logic       m_ov, m_conf;
  logic [7:0] m_ram [16];
  logic [7:0] obs_bus, exp_bus;

  always #5 clk = ~clk;

  sap1_datapath dut (
    .clk          (clk),
    .resetn       (resetn),
    .ctrl         (ctrl),
    .opcode       (opcode),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .bus_dbg      (bus_dbg),
    .bus_conflict (bus_conflict)
  );

  // A signal is asserted when its bit differs from the idle word.
  function automatic bit on(input logic [14:0] c, input logic [14:0] m);
    return ((c ^ IDLE) & m) != 15'h0;
  endfunction

  function automatic logic [7:0] model_bus(input logic [14:0] c);
    int sum;
    if (on(c, M_EP)) return {4'h0, m_pc};
    if (on(c, M_CE)) return m_ram[m_mar];
    if (on(c, M_EI)) return {4'h0, m_ir[3:0]};
    if (on(c, M_EA)) return m_a;
    if (on(c, M_EU)) begin
      if (on(c, M_SU)) sum = (int'(m_a) - int'(m_b) + 256) % 256;
      else             sum = (int'(m_a) + int'(m_b)) % 256;
      return sum[7:0];
    end
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0; m_a = 0; m_b = 0;
    m_out = 0; m_ov = 0; m_conf = 0;
  endtask

  // Apply one control word for one clock; samples the bus before the edge
  // and advances the model after it.
  task automatic step(input logic [14:0] c, input logic we,
                      input logic [3:0] wa, input logic [7:0] wd);
    int drivers;
    logic [7:0] nb;
    @(negedge clk);
    ctrl = c; prog_we = we; prog_addr = wa; prog_data = wd;
    #1;
    obs_bus = bus_dbg;
    nb = model_bus(c);
    exp_bus = nb;
    drivers = int'(on(c, M_EP)) + int'(on(c, M_CE)) + int'(on(c, M_EI))
            + int'(on(c, M_EA)) + int'(on(c, M_EU));
    @(posedge clk);
    #1;
    if (we)                m_ram[wa] = wd;
    else if (on(c, M_LR))  m_ram[m_mar] = m_mdr;
    if (on(c, M_LP))       m_pc = nb[3:0];
    else if (on(c, M_CP))  m_pc = (m_pc + 4'd1) % 16;
    if (on(c, M_LMA)) m_mar = nb[3:0];
    if (on(c, M_LMD)) m_mdr = nb;
    if (on(c, M_LI))  m_ir  = nb;
    if (on(c, M_LA))  m_a   = nb;
    if (on(c, M_LB))  m_b   = nb;
    if (on(c, M_LO))  m_out = nb;
    m_ov = on(c, M_LO);
    if (drivers >= 2) m_conf = 1'b1;
  endtask

  task automatic run(input logic [14:0] c);
    step(c, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic fetch();
    run(IDLE ^ (M_EP | M_LMA));
    run(IDLE ^ M_CP);
    run(IDLE ^ (M_CE | M_LI));
  endtask

  task automatic test_reset();
    resetn = 1'b1; ctrl = IDLE; prog_we = 0; prog_addr = 0; prog_data = 0;
    #2 resetn = 1'b0;
    model_reset();
    #1;
    vectors++; if (bus_dbg !== 8'h00) begin miscompares++; $display("FAIL rst_bus got %h exp 00", bus_dbg); end
    vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL rst_out got %h exp 00", out_data); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    vectors++; if (opcode !== 4'h0) begin miscompares++; $display("FAIL rst_opcode got %h exp 0", opcode); end
    vectors++; if (bus_conflict !== 1'b0) begin miscompares++; $display("FAIL rst_conflict got %b exp 0", bus_conflict); end
    ctrl = IDLE ^ M_EP; #1;
    vectors++; if (bus_dbg !== 8'h00) begin miscompares++; $display("FAIL rst_pc got %h exp 00", bus_dbg); end
    ctrl = IDLE ^ M_EA; #1;
    vectors++; if (bus_dbg !== 8'h00) begin miscompares++; $display("FAIL rst_a got %h exp 00", bus_dbg); end
    @(negedge clk); ctrl = IDLE; resetn = 1'b1;
  endtask

  task automatic load_program();
    logic [7:0] prog [16];
    prog = '{8'h4E, 8'h2F, 8'h10, 8'h4E, 8'h3F, 8'h3F, 8'h4C, 8'h5D,
             8'h5D, 8'h00, 8'h00, 8'h00, 8'h2A, 8'h00, 8'h05, 8'h03};
    for (int i = 0; i < 16; i++) step(IDLE, 1'b1, 4'(i), prog[i]);
  endtask

  task automatic test_lda();
    fetch();
    vectors++; if (obs_bus !== 8'h4E) begin miscompares++; $display("FAIL lda_t2_bus got %h exp 4e", obs_bus); end
    vectors++; if (opcode !== 4'h4) begin miscompares++; $display("FAIL lda_opcode got %h exp 4", opcode); end
    run(IDLE ^ (M_EI | M_LMA));
    vectors++; if (obs_bus !== 8'h0E) begin miscompares++; $display("FAIL lda_t3_bus got %h exp 0e", obs_bus); end
    run(IDLE ^ (M_CE | M_LA));
    run(IDLE);
    run(IDLE ^ M_EA);
    vectors++; if (obs_bus !== 8'h05) begin miscompares++; $display("FAIL lda_a got %h exp 05", obs_bus); end
    run(IDLE ^ M_EP);
    vectors++; if (obs_bus !== 8'h01) begin miscompares++; $display("FAIL lda_pc got %h exp 01", obs_bus); end
  endtask

  task automatic run_alu(input bit sub, input logic [7:0] want, input string name);
    fetch();
    run(IDLE ^ (M_EI | M_LMA));
    run(IDLE ^ (M_CE | M_LB));
    run(IDLE ^ (M_EU | M_LA | (sub ? M_SU : 15'h0)));
    vectors++; if (obs_bus !== want || obs_bus !== exp_bus) begin miscompares++; $display("FAIL %s got %h exp %h", name, obs_bus, want); end
  endtask

  task automatic test_add_sub();
    run_alu(1'b0, 8'h08, "add_5_3");
  endtask

  task automatic test_out();
    fetch();
    run(IDLE ^ (M_EA | M_LO));
    vectors++; if (out_data !== 8'h08) begin miscompares++; $display("FAIL out_data got %h exp 08", out_data); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL out_valid_hi got %b exp 1", out_valid); end
    run(IDLE);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL out_valid_lo got %b exp 0", out_valid); end
    vectors++; if (out_data !== 8'h08) begin miscompares++; $display("FAIL out_hold got %h exp 08", out_data); end
    run(IDLE);
    // LDA 14 then two SUB 15 steps, the second wrapping below zero
    fetch();
    run(IDLE ^ (M_EI | M_LMA));
    run(IDLE ^ (M_CE | M_LA));
    run(IDLE);
    run_alu(1'b1, 8'h02, "sub_5_3");
    run_alu(1'b1, 8'hFF, "sub_wrap");
  endtask

  task automatic test_sta();
    fetch();
    run(IDLE ^ (M_EI | M_LMA));
    run(IDLE ^ (M_CE | M_LA));
    run(IDLE);
    fetch();
    run(IDLE ^ (M_EI | M_LMA));
    vectors++; if (obs_bus !== 8'h0D) begin miscompares++; $display("FAIL sta_mar got %h exp 0d", obs_bus); end
    run(IDLE ^ (M_EA | M_LMD));
    vectors++; if (obs_bus !== 8'h2A) begin miscompares++; $display("FAIL sta_mdr got %h exp 2a", obs_bus); end
    run(IDLE ^ M_LR);
    run(IDLE ^ M_CE);
    vectors++; if (obs_bus !== 8'h2A || obs_bus !== m_ram[13]) begin miscompares++; $display("FAIL sta_ram got %h exp 2a", obs_bus); end
    fetch();
    run(IDLE ^ (M_EI | M_LMA));
    run(IDLE ^ (M_EA | M_LMD));
    step(IDLE ^ M_LR, 1'b1, 4'd13, 8'hC3);
    run(IDLE ^ M_CE);
    vectors++; if (obs_bus !== 8'hC3) begin miscompares++; $display("FAIL sta_prog_wins got %h exp c3", obs_bus); end
  endtask

  task automatic test_pc();
    run(IDLE ^ M_LP);
    for (int i = 0; i < 16; i++) run(IDLE ^ M_CP);
    run(IDLE ^ M_EP);
    vectors++; if (obs_bus !== 8'h00) begin miscompares++; $display("FAIL pc_wrap got %h exp 00", obs_bus); end
    step(IDLE, 1'b1, 4'd13, 8'h09);
    run(IDLE ^ (M_CE | M_LP | M_CP));
    run(IDLE ^ M_EP);
    vectors++; if (obs_bus !== 8'h09) begin miscompares++; $display("FAIL pc_load_wins got %h exp 09", obs_bus); end
  endtask

  task automatic test_conflict();
    step(IDLE, 1'b1, 4'd13, 8'h03);
    run(IDLE ^ (M_CE | M_LP));
    step(IDLE, 1'b1, 4'd13, 8'h77);
    run(IDLE ^ (M_CE | M_LA));
    vectors++; if (bus_conflict !== 1'b0) begin miscompares++; $display("FAIL conflict_pre got %b exp 0", bus_conflict); end
    run(IDLE ^ (M_EP | M_EA));
    vectors++; if (obs_bus !== 8'h03) begin miscompares++; $display("FAIL conflict_bus got %h exp 03", obs_bus); end
    vectors++; if (bus_conflict !== CHK_EN) begin miscompares++; $display("FAIL conflict_flag got %b exp %b", bus_conflict, CHK_EN); end
    run(IDLE);
    vectors++; if (bus_conflict !== CHK_EN) begin miscompares++; $display("FAIL conflict_sticky got %b exp %b", bus_conflict, CHK_EN); end
    // Reset mid-cycle, well away from either clock edge
    #2 resetn = 1'b0; model_reset();
    #1;
    vectors++; if (out_data !== 8'h00 || out_valid !== 1'b0 || opcode !== 4'h0) begin miscompares++; $display("FAIL midrst_regs got %h/%b/%h exp 00/0/0", out_data, out_valid, opcode); end
    vectors++; if (bus_conflict !== 1'b0) begin miscompares++; $display("FAIL midrst_conflict got %b exp 0", bus_conflict); end
    ctrl = IDLE ^ M_EA; #1;
    vectors++; if (bus_dbg !== 8'h00) begin miscompares++; $display("FAIL midrst_a got %h exp 00", bus_dbg); end
    @(negedge clk); ctrl = IDLE; resetn = 1'b1;
    run(IDLE ^ M_EP);
    vectors++; if (obs_bus !== 8'h00) begin miscompares++; $display("FAIL midrst_pc got %h exp 00", obs_bus); end
    fetch();
    run(IDLE ^ (M_EI | M_LMA));
    run(IDLE ^ M_CE);
    vectors++; if (obs_bus !== 8'h05) begin miscompares++; $display("FAIL midrst_ram14 got %h exp 05", obs_bus); end
  endtask

  task automatic test_random();
    logic [14:0] c;
    logic we;
    for (int i = 0; i < 16; i++) step(IDLE, 1'b1, 4'(i), 8'($urandom));
    for (int n = 0; n < 400; n++) begin
      c  = 15'($urandom);
      we = ($urandom_range(0, 7) == 0);
      step(c, we, 4'($urandom), 8'($urandom));
      vectors++; if (obs_bus !== exp_bus) begin miscompares++; $display("FAIL rnd_bus[%0d] ctrl %h got %h exp %h", n, c, obs_bus, exp_bus); end
      vectors++; if (out_data !== m_out || out_valid !== m_ov) begin miscompares++; $display("FAIL rnd_out[%0d] got %h/%b exp %h/%b", n, out_data, out_valid, m_out, m_ov); end
      vectors++; if (opcode !== m_ir[7:4]) begin miscompares++; $display("FAIL rnd_opcode[%0d] got %h exp %h", n, opcode, m_ir[7:4]); end
      vectors++; if (bus_conflict !== (CHK_EN & m_conf)) begin miscompares++; $display("FAIL rnd_conflict[%0d] got %b exp %b", n, bus_conflict, CHK_EN & m_conf); end
    end
  endtask

  initial begin
    test_reset();
    load_program();
    test_lda();
    test_add_sub();
    test_out();
    test_sta();
    test_pc();
    test_conflict();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
